// File: rtl/status_register_if.sv
// CPU-side bus bundle for the DMA status register.
// master: CPU / bus owner driving strobes and channel status inputs.
// slave:  status_register itself.
interface status_register_if;
    logic       IOR;
    logic       IOW;
    logic [3:0] address_in;
    logic [3:0] terminalCount;
    logic [3:0] requests;
    logic [3:0] maskedChannels;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output IOR,
        output IOW,
        output address_in,
        output terminalCount,
        output requests,
        output maskedChannels,
        input  data_out,
        input  data_oe
    );

    modport slave (
        input  IOR,
        input  IOW,
        input  address_in,
        input  terminalCount,
        input  requests,
        input  maskedChannels,
        output data_out,
        output data_oe
    );
endinterface

// File: rtl/status_register.sv
// DMA status register: sticky per-channel terminal-count flags plus live DREQ
// levels, read by the CPU with a two-state IDLE/ACTIVE handshake. Flags that
// were reported are cleared when IOR rises; a new TC on that edge still wins.
// Optional feature: define MASK_READBACK_EN to allow reading the channel mask
// at address 4'b1111 (same handshake, no flag clearing).
module status_register (
    input  logic                CLK,
    input  logic                reset,
    status_register_if.slave    bus
);
    localparam logic [3:0] STATUS_ADDR = 4'b1000;
    localparam logic [3:0] MASK_ADDR   = 4'b1111;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_tcFlags;
    logic [7:0] r_snapshot;
    logic       r_mask_rd;
    logic [7:0] r_data_out;
    logic       r_data_oe;

    logic       w_rd_ok;
    logic       w_rd_status;
    logic       w_rd_mask;
    logic [7:0] w_snap_next;
    logic [3:0] w_clr;

    // A read needs IOR low with IOW high; simultaneous strobes are contention.
    assign w_rd_ok     = !bus.IOR && bus.IOW;
    assign w_rd_status = w_rd_ok && (bus.address_in == STATUS_ADDR);

`ifdef MASK_READBACK_EN
    assign w_rd_mask   = w_rd_ok && (bus.address_in == MASK_ADDR);
`else
    assign w_rd_mask   = 1'b0;
`endif

    assign w_snap_next = w_rd_mask ? {4'b0000, bus.maskedChannels}
                                   : {bus.requests, r_tcFlags};

    // Only flags actually reported to the CPU are cleared, and only on the
    // edge that ends a status (not mask) read.
    assign w_clr = ((r_state == ACTIVE) && bus.IOR && !r_mask_rd)
                   ? r_snapshot[3:0] : 4'b0000;

    // Flag accumulation, read FSM and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tcFlags  <= 4'b0000;
            r_snapshot <= 8'h00;
            r_mask_rd  <= 1'b0;
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
        end else begin
            // Set is OR-ed after clear so a TC on the clearing edge survives.
            r_tcFlags <= (r_tcFlags & ~w_clr) | bus.terminalCount;
            case (r_state)
                IDLE: begin
                    if (w_rd_status || w_rd_mask) begin
                        r_state    <= ACTIVE;
                        r_snapshot <= w_snap_next;
                        r_mask_rd  <= w_rd_mask;
                        r_data_out <= w_snap_next;
                        r_data_oe  <= 1'b1;
                    end else begin
                        r_data_out <= 8'h00;
                        r_data_oe  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.IOR) begin
                        r_state    <= IDLE;
                        r_mask_rd  <= 1'b0;
                        r_data_out <= 8'h00;
                        r_data_oe  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_data_out <= 8'h00;
                    r_data_oe  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.data_oe  = r_data_oe;
endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench for status_register: stimulus pushes the expected byte for
// every cycle data_oe should be high; a negedge monitor pops and compares, and
// checks data_out is 8'h00 whenever data_oe is low.
module tb_status_register;
    logic CLK;
    logic reset;

    status_register_if bus_if ();

    status_register dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            checks++;
            if (bus_if.data_oe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_oe t=%0t data_oe=%b data_out=%h required data_oe=0",
                             $time, bus_if.data_oe, bus_if.data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus_if.data_out !== e) begin
                        failures++;
                        $display("FAIL read_data t=%0t data_out=%h required %h",
                                 $time, bus_if.data_out, e);
                    end
                end
            end else if (bus_if.data_oe !== 1'b0 || bus_if.data_out !== 8'h00) begin
                failures++;
                $display("FAIL idle_bus t=%0t data_oe=%b data_out=%h required 0/00",
                         $time, bus_if.data_oe, bus_if.data_out);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_tc(input logic [3:0] tc);
        bus_if.terminalCount = tc;
        tick();
        bus_if.terminalCount = 4'b0000;
    endtask

    // IOR low for n sampled edges at addr, then IOR high for one edge.
    // tc_at selects which sampled edge (1..n+1) also sees tc_val.
    task automatic do_read(input logic [3:0] addr, input int n, input logic [7:0] exp,
                           input bit push, input int tc_at, input logic [3:0] tc_val);
        if (push)
            for (int i = 0; i < n; i++) exp_q.push_back(exp);
        bus_if.address_in = addr;
        bus_if.IOW = 1'b1;
        bus_if.IOR = 1'b0;
        for (int i = 1; i <= n; i++) begin
            bus_if.terminalCount = (i == tc_at) ? tc_val : 4'b0000;
            tick();
        end
        bus_if.IOR = 1'b1;
        bus_if.terminalCount = (tc_at == n + 1) ? tc_val : 4'b0000;
        tick();
        bus_if.terminalCount = 4'b0000;
        bus_if.address_in = 4'b0000;
    endtask

    initial begin
        bus_if.IOR = 1'b1;
        bus_if.IOW = 1'b1;
        bus_if.address_in = 4'b0000;
        bus_if.terminalCount = 4'b0000;
        bus_if.requests = 4'b0000;
        bus_if.maskedChannels = 4'b0000;
        reset = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Basic status read: flags 0101, requests 0010 -> 8'h25 for 3 cycles.
        pulse_tc(4'b0101);
        bus_if.requests = 4'b0010;
        do_read(4'b1000, 3, 8'h25, 1'b1, 0, 4'b0000);
        do_read(4'b1000, 1, 8'h20, 1'b1, 0, 4'b0000);
        bus_if.requests = 4'b0000;
        tick();

        // TC during a read: snapshot stays 01, flag 2 survives the clear.
        pulse_tc(4'b0001);
        do_read(4'b1000, 4, 8'h01, 1'b1, 3, 4'b0100);
        do_read(4'b1000, 1, 8'h04, 1'b1, 0, 4'b0000);
        do_read(4'b1000, 1, 8'h00, 1'b1, 0, 4'b0000);

        // Data held stable while address/requests wander during the read.
        pulse_tc(4'b0010);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h32);
        bus_if.requests = 4'b0011;
        bus_if.address_in = 4'b1000;
        bus_if.IOR = 1'b0;
        tick();
        bus_if.address_in = 4'b0001;
        bus_if.requests = 4'b1100;
        tick();
        tick();
        bus_if.IOR = 1'b1;
        tick();
        bus_if.requests = 4'b0000;
        do_read(4'b1000, 1, 8'h00, 1'b1, 0, 4'b0000);

        // Set wins over clear on the IOR-rise edge.
        pulse_tc(4'b1000);
        do_read(4'b1000, 2, 8'h08, 1'b1, 3, 4'b1000);
        do_read(4'b1000, 1, 8'h08, 1'b1, 0, 4'b0000);
        do_read(4'b1000, 1, 8'h00, 1'b1, 0, 4'b0000);

        // IOR low before the address matches: read starts when decode is true.
        bus_if.address_in = 4'b0011;
        bus_if.IOR = 1'b0;
        tick();
        tick();
        pulse_tc(4'b0110);
        do_read(4'b1000, 2, 8'h06, 1'b1, 0, 4'b0000);

        // Reset mid-read: aborts, flags cleared, fresh read returns 00.
        pulse_tc(4'b1111);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        bus_if.address_in = 4'b1000;
        bus_if.IOR = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        bus_if.IOR = 1'b1;
        tick();
        do_read(4'b1000, 1, 8'h00, 1'b1, 0, 4'b0000);

        // Contention (IOR and IOW both low) and plain writes: no read, no effect.
        pulse_tc(4'b0011);
        bus_if.address_in = 4'b1000;
        bus_if.IOW = 1'b0;
        bus_if.IOR = 1'b0;
        tick();
        tick();
        tick();
        bus_if.IOR = 1'b1;
        tick();
        bus_if.address_in = 4'b1111;
        tick();
        bus_if.IOW = 1'b1;
        tick();

        // Mask readback: only present with MASK_READBACK_EN; never clears flags.
        bus_if.maskedChannels = 4'b1010;
`ifdef MASK_READBACK_EN
        do_read(4'b1111, 2, 8'h0A, 1'b1, 0, 4'b0000);
`else
        do_read(4'b1111, 2, 8'h0A, 1'b0, 0, 4'b0000);
`endif
        do_read(4'b1000, 1, 8'h03, 1'b1, 0, 4'b0000);
        do_read(4'b1000, 1, 8'h00, 1'b1, 0, 4'b0000);

        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_reads pending=%0d required 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/status_register.md
STATUS_REGISTER -- requirements
Module: status_register

Interface
REQ-001 The module SHALL have exactly one clock and one reset: the clock is CLK and the reset is reset, which is synchronous and active-high.
REQ-002 Port CLK SHALL be an input, 1 bit wide: the system clock, with all state updated on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-004 Port IOR SHALL be an input, 1 bit wide: the CPU read strobe, active low.
REQ-005 Port IOW SHALL be an input, 1 bit wide: the CPU write strobe, active low.
REQ-006 Port address_in SHALL be an input, 4 bits wide: the CPU register address.
REQ-007 Port terminalCount SHALL be an input, 4 bits wide: per-channel terminal-count pulses, one CLK cycle each.
REQ-008 Port requests SHALL be an input, 4 bits wide: per-channel DREQ levels, already synchronized to CLK.
REQ-009 Port maskedChannels SHALL be an input, 4 bits wide: the current channel mask, where 1 means masked.
REQ-010 Port data_out SHALL be an output, 8 bits wide: read data driven to the CPU.
REQ-011 Port data_oe SHALL be an output, 1 bit wide: bus drive enable, active high.

Function
REQ-012 The module SHALL hold internal tcFlags[3:0]; for each channel n, tcFlags[n] is set in the cycle after terminalCount[n]=1 is sampled.
REQ-013 The module SHALL use an FSM with the states IDLE and ACTIVE.
- A status read is decoded when address_in=4'b1000, IOR=0 and IOW=1.
REQ-014 In IDLE, when a status read is decoded, the FSM SHALL move to ACTIVE.
- The same edge latches snapshot = {requests, tcFlags}.
REQ-015 In ACTIVE, the module SHALL drive data_out=snapshot and data_oe=1.
- This starts the cycle after the read is decoded (1-cycle latency).
- Both values hold stable while IOR=0, even if address_in or requests change.
REQ-016 In ACTIVE, when IOR=1 is sampled, the FSM SHALL return to IDLE.
- The same edge clears only the tcFlags bits that were 1 in snapshot[3:0].
- data_oe=0 from the next cycle.
REQ-017 If terminalCount[n]=1 arrives while the read is ACTIVE or on the clearing edge, tcFlags[n] SHALL end at 1.
- Set wins over clear; the new event is never lost.
REQ-018 In IDLE, data_out SHALL be 8'h00 and data_oe SHALL be 0.
REQ-019 With IOR=0 and IOW=0 together, the module SHALL decode no read, stay in IDLE and leave tcFlags unchanged apart from terminalCount sets.
REQ-020 If IOR is held low from before address_in matches, the read SHALL start on the first cycle the full decode is true.
REQ-021 Each IOR low period SHALL clear flags at most once, so back-to-back reads need IOR=1 for at least one cycle between them.
REQ-022 Writes (IOW=0) to any address SHALL have no effect on this block.

Reset
REQ-023 While reset=1 at a CLK edge, tcFlags and snapshot SHALL be 0, the FSM SHALL be IDLE, data_out SHALL be 8'h00 and data_oe SHALL be 0.
- Reset overrides terminalCount, IOR and all other inputs.
REQ-024 A reset asserted mid-read SHALL abort the read: data_oe=0 the next cycle, and no clear-on-read happens after reset releases.
- If IOR is still low after release, the read is decoded afresh per REQ-014 and REQ-020.

Configuration
REQ-025 When the macro MASK_READBACK_EN is defined, a read at address_in=4'b1111 (IOR=0, IOW=1) SHALL follow the same IDLE/ACTIVE handshake.
- It returns data_out={4'b0000, maskedChannels} with 1-cycle latency.
- It does not clear tcFlags.
REQ-026 When MASK_READBACK_EN is not defined, address 4'b1111 SHALL never be decoded; data_oe stays 0 for such reads.

Verification
REQ-027 The bench SHALL cover the basic status read.
- Stimulus: reset; pulse terminalCount=4'b0101; requests=4'b0010; IOR=0 at address 4'b1000 for 3 cycles, then IOR=1.
- Expected: data_out=8'h25 with data_oe=1 from cycle 2; tcFlags=0 after IOR rises.
REQ-028 The bench SHALL cover a TC arriving during a read.
- Stimulus: tcFlags=4'b0001; start a read; pulse terminalCount[2] mid-read.
- Expected: data_out=8'h01 during the read; tcFlags=4'b0100 afterwards.
REQ-029 The bench SHALL cover set-wins-over-clear.
- Stimulus: tcFlags=4'b1000; terminalCount[3]=1 on the IOR-rise edge.
- Expected: tcFlags=4'b1000 afterwards.
REQ-030 The bench SHALL cover reset mid-read.
- Stimulus: tcFlags=4'b1111; reset=1 for 1 cycle while IOR=0.
- Expected: data_oe=0 and tcFlags=0 next cycle; a new read returns 8'h00.
REQ-031 The bench SHALL cover contention and the mask read.
- Stimulus: IOR=0 and IOW=0 at address 4'b1000; then, with MASK_READBACK_EN defined and maskedChannels=4'b1010, a read at address 4'b1111.
- Expected: data_oe=0 for the contention case; data_out=8'h0A for the mask read with tcFlags unchanged.
- Without the macro, the same mask read gives data_oe=0.
